conv_scan_ctrl: RTL and testbench
=================================

# conv_scan_ctrl

Scan controller for the 3×3 convolution weight path. It generates the kernel-tap counters (x, y) and output-position counters (X, Y) that drive the weight-register stages, and the matching weight-memory read address. On a start request it walks one full frame: x innermost, then y, then X, then Y. It flags window and frame boundaries for the stages that load, shift and hand back weights, and pulses finish when the frame ends.

## Interface
Parameters:
- KW, 3, kernel width; x and y each count 0..KW-1 (KW*KW ≤ 16).
- OW, 19, output width/height; X and Y each count 0..OW-1 (OW ≤ 32).

Ports:
- clk  in  1  clock, rising edge.
- xrst  in  1  asynchronous active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- en  in  1  advance enable; low freezes counters (downstream stall).
- busy  out  1  high while in RUN.
- tap_valid  out  1  current (x,y,X,Y) tuple is valid; equals busy.
- x  out  2  kernel column, 0..KW-1.
- y  out  2  kernel row, 0..KW-1.
- X  out  5  output column, 0..OW-1.
- Y  out  5  output row, 0..OW-1.
- w_raddr  out  4  weight-memory address = y*KW + x.
- kernel_load  out  1  tap_valid && x=y=X=Y=0 (fetch kernel from memory).
- win_first  out  1  tap_valid && x=0 && y=0.
- win_last  out  1  tap_valid && x=KW-1 && y=KW-1 (window complete).
- row_end  out  1  win_last && X=OW-1 (weights return to origin).
- finish  out  1  one-cycle pulse after the last tuple.

## Operation
- FSM has two states, IDLE and RUN. There is no DONE state; finish is a registered pulse raised on leaving RUN.
- IDLE: all counters hold 0. When start=1 at a clock edge, the FSM enters RUN with all counters at 0.
- RUN, en=1 at the edge:
  - x increments.
  - When x=KW-1, x wraps to 0 and y increments.
  - When y also wraps, X increments.
  - When X also wraps, Y increments.
- RUN, en=0: all counters, strobes and w_raddr hold their values. busy stays 1.
- Last tuple (KW-1, KW-1, OW-1, OW-1) with en=1:
  - Next state is IDLE.
  - All counters go to 0.
  - finish=1 for exactly that following cycle.
- start while in RUN is ignored and is not queued.
- start=1 in the cycle where finish=1 (FSM already in IDLE) is accepted; the next run begins on that edge.
- w_raddr and all strobes are combinational from the registered counters and state. They are glitch-free relative to clk and valid in the same cycle as the tuple.
- Arithmetic: y*KW+x is computed at 4 bits. It cannot overflow given KW*KW ≤ 16.
- Reset asserted at any time, including mid-run:
  - Immediate return to IDLE.
  - All outputs 0.
  - No finish pulse.

## Timing
- Reset values: busy=0, tap_valid=0, x=y=X=Y=0, w_raddr=0, kernel_load=win_first=win_last=row_end=0, finish=0.
- start sampled at edge E0: from E0, busy=1, tuple (0,0,0,0) and kernel_load=1.
- With en held high, tuple k is presented after edge Ek.
- Frame length is KW*KW*OW*OW tuples: 3249 with defaults.
- Last tuple appears after E3248. At E3249: finish=1, busy=0.
- Each en=0 cycle delays every later event by exactly one cycle.
- Latency start→first tuple: 1 edge. Latency last tuple→finish: 1 edge (if en=1).

## Test plan
- Reset: hold xrst=0, then release → every output 0; busy stays 0 until start is given.
- Full frame with en=1: pulse start → busy high for 3249 cycles. Check:
  - kernel_load exactly once.
  - win_last 361 times.
  - row_end 19 times.
  - finish exactly once, at cycle 3249 after the start edge.
- Wrap: at tuple (2,2,5,3) with en=1 → next tuple is (0,0,6,3) and w_raddr goes 8→0. At tuple (2,2,18,3) → next is (0,0,0,4).
- Stall: drop en for 4 cycles at tuple (1,2,7,0) → tuple and w_raddr=7 hold for 4 cycles; finish arrives 4 cycles later than the no-stall case.
- start pulsed mid-run → ignored, frame length unchanged. start=1 during the finish cycle → busy=1 on the next cycle, tuple (0,0,0,0).
- Reset asserted at tuple (1,1,10,10) → all outputs 0 immediately and no finish pulse; a following start runs a full 3249-cycle frame.

Source files
------------

// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: kernel-tap (x,y) and output-position (X,Y) scan for the 3x3 weight path.
// Rev 1.0 -- initial release.
`default_nettype none

module conv_scan_ctrl #(
  parameter int KW = 3,
  parameter int OW = 19
) (
  input  logic       clk,
  input  logic       xrst,
  input  logic       start,
  input  logic       en,
  output logic       busy,
  output logic       tap_valid,
  output logic [1:0] x,
  output logic [1:0] y,
  output logic [4:0] X,
  output logic [4:0] Y,
  output logic [3:0] w_raddr,
  output logic       kernel_load,
  output logic       win_first,
  output logic       win_last,
  output logic       row_end,
  output logic       finish
);

  localparam logic [1:0] K_LAST = 2'(KW - 1);
  localparam logic [4:0] P_LAST = 5'(OW - 1);
  localparam logic [3:0] KW4    = 4'(KW);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t     state_q;
  logic [1:0] x_q, y_q, x_d, y_d;
  logic [4:0] X_q, Y_q, X_d, Y_d;
  logic       finish_q;
  logic       x_wrap, y_wrap, col_wrap, row_wrap, last_tap;

  // Odometer advance: x innermost, then y, then X, then Y.
  always_comb begin
    x_wrap   = (x_q == K_LAST);
    y_wrap   = (y_q == K_LAST);
    col_wrap = (X_q == P_LAST);
    row_wrap = (Y_q == P_LAST);
    last_tap = x_wrap && y_wrap && col_wrap && row_wrap;
    x_d      = x_wrap ? 2'd0 : x_q + 2'd1;
    y_d      = y_q;
    X_d      = X_q;
    Y_d      = Y_q;
    if (x_wrap) begin
      y_d = y_wrap ? 2'd0 : y_q + 2'd1;
      if (y_wrap) begin
        X_d = col_wrap ? 5'd0 : X_q + 5'd1;
        if (col_wrap) begin
          Y_d = Y_q + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      X_q      <= '0;
      Y_q      <= '0;
      finish_q <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (en) begin
            if (last_tap) begin
              state_q  <= S_IDLE;
              x_q      <= '0;
              y_q      <= '0;
              X_q      <= '0;
              Y_q      <= '0;
              finish_q <= 1'b1;
            end else begin
              x_q <= x_d;
              y_q <= y_d;
              X_q <= X_d;
              Y_q <= Y_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Counters stay zero outside RUN, so only the strobes need gating by busy.
  assign busy        = (state_q == S_RUN);
  assign tap_valid   = busy;
  assign x           = x_q;
  assign y           = y_q;
  assign X           = X_q;
  assign Y           = Y_q;
  assign w_raddr     = ({2'b00, y_q} * KW4) + {2'b00, x_q};
  assign win_first   = busy && (x_q == 2'd0) && (y_q == 2'd0);
  assign kernel_load = win_first && (X_q == 5'd0) && (Y_q == 5'd0);
  assign win_last    = busy && x_wrap && y_wrap;
  assign row_end     = win_last && col_wrap;
  assign finish      = finish_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_scan_ctrl.sv
// tb_conv_scan_ctrl: scoreboard bench for conv_scan_ctrl with default KW=3, OW=19.
`default_nettype none

module tb_conv_scan_ctrl;

  localparam int KW    = 3;
  localparam int OW    = 19;
  localparam int FRAME = KW * KW * OW * OW;

  logic       clk = 1'b0;
  logic       xrst;
  logic       start;
  logic       en;
  logic       busy, tap_valid, kernel_load, win_first, win_last, row_end, finish;
  logic [1:0] x, y;
  logic [4:0] X, Y;
  logic [3:0] w_raddr;

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic [4:0] X;
    logic [4:0] Y;
    logic [3:0] a;
    logic       kl;
    logic       wf;
    logic       wl;
    logic       re;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic fin_pending = 1'b0;

  conv_scan_ctrl #(.KW(KW), .OW(OW)) dut (
    .clk(clk), .xrst(xrst), .start(start), .en(en),
    .busy(busy), .tap_valid(tap_valid), .x(x), .y(y), .X(X), .Y(Y),
    .w_raddr(w_raddr), .kernel_load(kernel_load), .win_first(win_first),
    .win_last(win_last), .row_end(row_end), .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic push_frame();
    exp_t e;
    for (int yy = 0; yy < OW; yy++)
      for (int xx = 0; xx < OW; xx++)
        for (int ky = 0; ky < KW; ky++)
          for (int kx = 0; kx < KW; kx++) begin
            e.x    = 2'(kx);
            e.y    = 2'(ky);
            e.X    = 5'(xx);
            e.Y    = 5'(yy);
            e.a    = 4'(ky * KW + kx);
            e.kl   = (kx == 0 && ky == 0 && xx == 0 && yy == 0);
            e.wf   = (kx == 0 && ky == 0);
            e.wl   = (kx == KW - 1 && ky == KW - 1);
            e.re   = (kx == KW - 1 && ky == KW - 1 && xx == OW - 1);
            e.last = (kx == KW - 1 && ky == KW - 1 && xx == OW - 1 && yy == OW - 1);
            sb.push_back(e);
          end
  endtask

  // Scoreboard monitor on the falling edge; pops an entry only when en lets the DUT advance.
  always @(negedge clk) begin
    exp_t e;
    exp_t o;
    if (!xrst) begin
      fin_pending = 1'b0;
      checks++;
      if ({busy, tap_valid, x, y, X, Y, w_raddr, kernel_load, win_first, win_last, row_end, finish} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got busy=%b x=%0d y=%0d X=%0d Y=%0d a=%0d fin=%b, want all 0",
                 busy, x, y, X, Y, w_raddr, finish);
      end
    end else begin
      checks++;
      if (finish !== fin_pending) begin
        errors++;
        $display("FAIL finish_pulse: got %b want %b at %0t", finish, fin_pending, $time);
      end
      fin_pending = 1'b0;
      if (busy) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: got busy=1 with tuple (%0d,%0d,%0d,%0d), want busy=0", x, y, X, Y);
        end else begin
          e = sb[0];
          o = {x, y, X, Y, w_raddr, kernel_load, win_first, win_last, row_end, e.last};
          checks++;
          if (o !== e || tap_valid !== 1'b1) begin
            errors++;
            $display("FAIL tuple: got x=%0d y=%0d X=%0d Y=%0d a=%0d kl%b wf%b wl%b re%b tv%b, want x=%0d y=%0d X=%0d Y=%0d a=%0d kl%b wf%b wl%b re%b tv1",
                     x, y, X, Y, w_raddr, kernel_load, win_first, win_last, row_end, tap_valid,
                     e.x, e.y, e.X, e.Y, e.a, e.kl, e.wf, e.wl, e.re);
          end
          if (en) begin
            void'(sb.pop_front());
            fin_pending = e.last;
          end
        end
      end else begin
        checks++;
        if ({tap_valid, x, y, X, Y, w_raddr, kernel_load, win_first, win_last, row_end} !== '0) begin
          errors++;
          $display("FAIL idle_outputs: got tv=%b x=%0d y=%0d X=%0d Y=%0d a=%0d, want all 0",
                   tap_valid, x, y, X, Y, w_raddr);
        end
      end
    end
  end

  // Drives one frame (optionally started here) and reports what it observed; callers check.
  task automatic run_frame(input bit do_start, input int stall_at, input int stall_len,
                           input int mid_start_at, input bit fin_start,
                           output int busy_cnt, output int fin_idx, output int kl_cnt,
                           output int wl_cnt, output int re_cnt, output int fin_cnt,
                           output logic [3:0] st_a, output logic [13:0] st_tuple);
    bit done;
    busy_cnt = 0; fin_idx = -1; kl_cnt = 0; wl_cnt = 0; re_cnt = 0; fin_cnt = 0;
    st_a = '1; st_tuple = '1;
    if (do_start) begin
      push_frame();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      en    = (i >= stall_at && i < stall_at + stall_len) ? 1'b0 : 1'b1;
      start = (i == mid_start_at);
      if (busy) busy_cnt++;
      if (kernel_load) kl_cnt++;
      if (win_last && en) wl_cnt++;
      if (row_end && en) re_cnt++;
      if (i == stall_at + stall_len - 1) begin
        st_a     = w_raddr;
        st_tuple = {x, y, X, Y};
      end
      if (finish) begin
        fin_cnt++;
        if (fin_idx < 0) fin_idx = i;
        if (fin_start) begin
          push_frame();
          start = 1'b1;
        end
      end
      done = (fin_idx >= 0);
      @(posedge clk); #1;
      if (done) break;
    end
    start = 1'b0;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    xrst = 1'b0; start = 1'b0; en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, finish, x, y, X, Y, w_raddr} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got busy=%b fin=%b a=%0d, want 0", busy, finish, w_raddr);
    end
    xrst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_full_frame();
    int bc, fi, kl, wl, re, fc;
    logic [3:0] sa;
    logic [13:0] st;
    run_frame(1'b1, -10, 0, -1, 1'b0, bc, fi, kl, wl, re, fc, sa, st);
    checks++; if (bc != FRAME) begin errors++; $display("FAIL full_busy_cycles: got %0d want %0d", bc, FRAME); end
    checks++; if (fi != FRAME) begin errors++; $display("FAIL full_finish_idx: got %0d want %0d", fi, FRAME); end
    checks++; if (kl != 1)     begin errors++; $display("FAIL full_kernel_load: got %0d want 1", kl); end
    checks++; if (wl != OW*OW) begin errors++; $display("FAIL full_win_last: got %0d want %0d", wl, OW*OW); end
    checks++; if (re != OW)    begin errors++; $display("FAIL full_row_end: got %0d want %0d", re, OW); end
    checks++; if (fc != 1)     begin errors++; $display("FAIL full_finish_cnt: got %0d want 1", fc); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL full_sb_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_wrap();
    bit found;
    push_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if ({x, y, X, Y} == {2'd2, 2'd2, 5'd5, 5'd3}) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!found || w_raddr !== 4'd8) begin errors++; $display("FAIL wrap_a_pre: got found=%0d a=%0d want 1 8", found, w_raddr); end
    @(posedge clk); #1;
    checks++;
    if ({x, y, X, Y, w_raddr} !== {2'd0, 2'd0, 5'd6, 5'd3, 4'd0}) begin
      errors++; $display("FAIL wrap_a_post: got (%0d,%0d,%0d,%0d) a=%0d want (0,0,6,3) a=0", x, y, X, Y, w_raddr);
    end
    found = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if ({x, y, X, Y} == {2'd2, 2'd2, 5'd18, 5'd3}) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!found || row_end !== 1'b1) begin errors++; $display("FAIL wrap_b_pre: got found=%0d row_end=%b want 1 1", found, row_end); end
    @(posedge clk); #1;
    checks++;
    if ({x, y, X, Y} !== {2'd0, 2'd0, 5'd0, 5'd4}) begin
      errors++; $display("FAIL wrap_b_post: got (%0d,%0d,%0d,%0d) want (0,0,0,4)", x, y, X, Y);
    end
    xrst = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    xrst = 1'b1;
  endtask

  task automatic test_stall();
    int bc, fi, kl, wl, re, fc;
    logic [3:0] sa;
    logic [13:0] st;
    run_frame(1'b1, 70, 4, -1, 1'b0, bc, fi, kl, wl, re, fc, sa, st);
    checks++; if (st !== {2'd1, 2'd2, 5'd7, 5'd0}) begin errors++; $display("FAIL stall_tuple: got %h want %h", st, {2'd1, 2'd2, 5'd7, 5'd0}); end
    checks++; if (sa !== 4'd7) begin errors++; $display("FAIL stall_raddr: got %0d want 7", sa); end
    checks++; if (fi != FRAME + 4) begin errors++; $display("FAIL stall_finish_idx: got %0d want %0d", fi, FRAME + 4); end
    checks++; if (fc != 1) begin errors++; $display("FAIL stall_finish_cnt: got %0d want 1", fc); end
  endtask

  task automatic test_start_mid_run();
    int bc, fi, kl, wl, re, fc;
    logic [3:0] sa;
    logic [13:0] st;
    run_frame(1'b1, -10, 0, 1000, 1'b0, bc, fi, kl, wl, re, fc, sa, st);
    checks++; if (fi != FRAME) begin errors++; $display("FAIL midstart_finish_idx: got %0d want %0d", fi, FRAME); end
    checks++; if (bc != FRAME) begin errors++; $display("FAIL midstart_busy_cycles: got %0d want %0d", bc, FRAME); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midstart_not_queued: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int bc, fi, kl, wl, re, fc;
    logic [3:0] sa;
    logic [13:0] st;
    run_frame(1'b1, -10, 0, -1, 1'b1, bc, fi, kl, wl, re, fc, sa, st);
    checks++;
    if ({busy, x, y, X, Y, kernel_load} !== {1'b1, 14'd0, 1'b1}) begin
      errors++; $display("FAIL b2b_restart: got busy=%b (%0d,%0d,%0d,%0d) kl=%b want busy=1 (0,0,0,0) kl=1",
                         busy, x, y, X, Y, kernel_load);
    end
    run_frame(1'b0, -10, 0, -1, 1'b0, bc, fi, kl, wl, re, fc, sa, st);
    checks++; if (fi != FRAME) begin errors++; $display("FAIL b2b_second_finish_idx: got %0d want %0d", fi, FRAME); end
  endtask

  task automatic test_reset_mid_run();
    int bc, fi, kl, wl, re, fc;
    logic [3:0] sa;
    logic [13:0] st;
    bit found;
    push_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if ({x, y, X, Y} == {2'd1, 2'd1, 5'd10, 5'd10}) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach: got found=0 want 1"); end
    xrst = 1'b0;
    #1;
    checks++;
    if ({busy, tap_valid, x, y, X, Y, w_raddr, win_first, win_last, finish} !== '0) begin
      errors++; $display("FAIL rstmid_immediate: got busy=%b (%0d,%0d,%0d,%0d) a=%0d want all 0", busy, x, y, X, Y, w_raddr);
    end
    sb.delete();
    @(posedge clk); #1;
    xrst = 1'b1;
    @(posedge clk); #1;
    checks++; if (finish !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_finish: got fin=%b busy=%b want 0 0", finish, busy); end
    run_frame(1'b1, -10, 0, -1, 1'b0, bc, fi, kl, wl, re, fc, sa, st);
    checks++; if (bc != FRAME || fi != FRAME) begin errors++; $display("FAIL rstmid_next_frame: got busy=%0d fin_idx=%0d want %0d", bc, fi, FRAME); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_wrap();
    test_stall();
    test_start_mid_run();
    test_back_to_back();
    test_reset_mid_run();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
